// File: rtl/disp_scan_mux.sv
// Six-digit multiplexed 7-segment scanner with per-slot blanking and frame-latched digit codes.
// Define LEADING_ZERO_BLANK_EN to blank the hrm digit whenever its code equals ZERO_PAT.
module disp_scan_mux #(
   parameter int unsigned DIV      = 1000,
   parameter int unsigned DEAD     = 2,
   parameter logic [6:0]  ZERO_PAT = 7'b1111110
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] hrm,
   input  logic [6:0] hrl,
   input  logic [6:0] minm,
   input  logic [6:0] minl,
   input  logic [6:0] secm,
   input  logic [6:0] secl,
   output logic [6:0] seg,
   output logic [5:0] an,
   output logic       frame_start
);

   localparam int unsigned CW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZB_EN = 1'b1;
`else
   localparam bit LZB_EN = 1'b0;
`endif

   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic          run_q;
   logic [6:0]    shadow_q [6];
   logic [6:0]    shadow_d [6];
   logic          load;
   logic          in_dead;
   logic          lz_blank;
   logic          blank;
   logic [6:0]    seg_d;
   logic [5:0]    an_d;
   logic          frame_start_d;

   // NOTE: every variable written here gets a default first, so no path can infer a latch.
   always_comb begin
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      load     = 1'b0;
      shadow_d = shadow_q;
      if (!run_q) begin
         cnt_d = '0;
         idx_d = '0;
         load  = 1'b1;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d = '0;
         if (idx_q == 3'd5) begin
            idx_d = '0;
            load  = 1'b1;
         end else begin
            idx_d = idx_q + 3'd1;
         end
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
      if (load) shadow_d = '{hrm, hrl, minm, minl, secm, secl};
   end

   // A zero-length dead time must not produce a constant unsigned compare.
   generate
      if (DEAD == 0) begin : g_no_dead
         assign in_dead = 1'b0;
      end else begin : g_dead
         assign in_dead = (cnt_d < CW'(DEAD));
      end
   endgenerate

   assign lz_blank = LZB_EN && (idx_d == 3'd0) && (shadow_d[0] == ZERO_PAT);
   assign blank    = in_dead || lz_blank;

   // Outputs are derived from next-state so they line up with the (idx,cnt) they describe.
   always_comb begin
      an_d          = blank ? 6'b000000 : (6'b100000 >> idx_d);
      seg_d         = blank ? 7'b0000000 : shadow_d[idx_d];
      frame_start_d = (idx_d == 3'd0) && (cnt_d == '0);
   end

   // NOTE: the six shadow registers are reset like ordinary flops; they must read 0 during reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         idx_q       <= '0;
         run_q       <= 1'b0;
         seg         <= '0;
         an          <= '0;
         frame_start <= 1'b0;
         for (int i = 0; i < 6; i++) shadow_q[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         run_q       <= 1'b1;
         seg         <= seg_d;
         an          <= an_d;
         frame_start <= frame_start_d;
         shadow_q    <= shadow_d;
      end
   end

endmodule
